q2_bus_responder: RTL and testbench
===================================

// Module: q2_bus_responder
// PURPOSE
//  Memory/IO responder on the far end of the Q2 CPU bus: services CPU read/write/IO strobes issued
//  by the control unit, answering with data and the ws (wait-state done) handshake.
//  Also runs front-panel deposit/examine against the same synchronous RAM while the CPU is halted.
//  Sits between the discrete CPU bus and an FPGA block RAM plus the panel switches and lamps.
// PARAMETERS
//  ADDR_W    12     address width (P/X register width)
//  DATA_W    8      data bus width
//  IO_ADDR   12'hFFF  single IO-mapped address, decoded only when cpu_io=1
//  DEBOUNCE  16'd50000  cycles a panel switch must be stable before it is accepted
// PORTS
//  clk           in   1       system clock
//  rst           in   1       asynchronous, active-high reset
//  cpu_addr      in   ADDR_W  address from CPU X/P mux
//  cpu_rd        in   1       read request, active high (async to clk)
//  cpu_nwr       in   1       write strobe, active low (async to clk)
//  cpu_io        in   1       access targets IO space when high
//  dbus_in       in   DATA_W  CPU write data
//  dbus_out      out  DATA_W  read data to CPU
//  dbus_oe       out  1       dbus_out valid / drive enable
//  cpu_ws        out  1       cycle complete; CPU holds strobes until seen
//  mem_addr      out  ADDR_W  RAM address
//  mem_wdata     out  DATA_W  RAM write data
//  mem_we        out  1       RAM write enable, one-cycle pulse
//  mem_rdata     in   DATA_W  RAM read data, 1-cycle latency
//  io_in         in   DATA_W  input port
//  io_out        out  DATA_W  output port latch
//  fp_run        in   1       1=CPU running (CPU owns RAM), 0=halted (panel owns RAM)
//  fp_addr_sw    in   ADDR_W  panel address switches
//  fp_data_sw    in   DATA_W  panel data switches
//  fp_dep_sw     in   1       deposit momentary switch
//  fp_exam_sw    in   1       examine momentary switch
//  fp_load_sw    in   1       load address pointer (used only with Q2_FP_AUTOINC_EN)
//  fp_addr_lamp  out  ADDR_W  address of last completed access
//  fp_data_lamp  out  DATA_W  data of last completed access
// BEHAVIOUR
//  - Reset: state IDLE; dbus_out, dbus_oe, cpu_ws, mem_we, mem_addr, mem_wdata, io_out, lamps all 0.
//  - cpu_rd, cpu_nwr, cpu_io and all fp_* switches pass 2-flop synchronizers; cpu_nwr syncs reset to 1.
//  - Panel switches debounced: level accepted after DEBOUNCE stable cycles; action on accepted rising edge.
//  - FSM IDLE -> RD_ADDR -> RD_DATA -> RD_HOLD -> IDLE; IDLE -> WR -> WR_HOLD -> IDLE;
//    IDLE -> FP_DEP -> IDLE; IDLE -> FP_EXAM -> FP_EXAM_DATA -> IDLE.
//  - IDLE, fp_run=1: synced nwr low -> WR; else synced rd -> RD_ADDR. Write wins if both.
//    Panel edges ignored (and discarded) while fp_run=1.
//  - IDLE, fp_run=0: dep edge -> FP_DEP; exam edge -> FP_EXAM; same cycle: deposit wins. CPU strobes ignored.
//  - Address and cpu_io latched on IDLE exit; held for the whole cycle.
//  - RD_ADDR: mem_addr driven. RD_DATA: dbus_out<=mem_rdata (or io_in if IO hit, no RAM use),
//    dbus_oe=1, cpu_ws=1. RD_HOLD: hold until synced rd=0, then dbus_oe=0, cpu_ws=0 next cycle.
//    Read latency: strobe-to-ws = 2 sync + 2 cycles.
//  - WR: dbus_in sampled; mem_we=1 for exactly one cycle (or io_out<=data if IO hit, mem_we stays 0);
//    cpu_ws=1 in WR_HOLD until synced nwr=1, then 0.
//  - IO hit = cpu_io=1 and addr==IO_ADDR; cpu_io=1 with other addr accesses RAM normally.
//  - FP_DEP: mem_we pulse with fp_data_sw at panel address. FP_EXAM: read panel address -> lamps.
//  - Lamps update on every completed access (CPU or panel).
//  - fp_run change mid-cycle: current cycle completes; new owner takes effect from IDLE.
//  - Async rst mid-cycle: immediate return to reset values; in-progress write discarded if mem_we not yet asserted.
// CONFIGURATION
//  - Q2_FP_AUTOINC_EN defined: internal panel pointer; fp_load_sw edge loads it from fp_addr_sw;
//    each deposit/examine uses pointer then increments it, wrapping all-ones -> 0.
//  - Undefined: panel address is always fp_addr_sw; fp_load_sw ignored; no pointer register.
// STRUCTURE
//  - Package q2_bus_pkg: state enum typedef, IO_ADDR default, DEBOUNCE default.
//  - Sub-module q2_sync_debounce: 2-flop sync + stable counter + rising-edge pulse; one per panel switch.
// TESTING
//  - CPU write 0x5A @0x123, then read @0x123 -> mem_we single pulse; dbus_out=0x5A, ws high until rd drops.
//  - cpu_io=1 write 0x3C @IO_ADDR -> io_out=0x3C, mem_we never asserted; IO read returns io_in.
//  - fp_run=0, switches 0x040/0xA5, deposit; examine -> RAM[0x040]=0xA5, lamps 0x040/0xA5.
//  - Switch bounce shorter than DEBOUNCE -> no action; dep+exam same edge -> deposit only.
//  - rst asserted in RD_DATA -> dbus_oe=0, cpu_ws=0 same cycle; next CPU read completes normally.
//  - With Q2_FP_AUTOINC_EN: load 0xFFF, two deposits -> writes at 0xFFF then 0x000.

Source files
------------

// File: rtl/q2_bus_pkg.sv
// rtl/q2_bus_pkg.sv - shared state encoding and parameter defaults for the Q2 bus responder
package q2_bus_pkg;

   localparam logic [11:0] IO_ADDR_DEF  = 12'hFFF;
   localparam logic [15:0] DEBOUNCE_DEF = 16'd50000;

   typedef enum logic [3:0] {
      ST_IDLE         = 4'd0,
      ST_RD_ADDR      = 4'd1,
      ST_RD_DATA      = 4'd2,
      ST_RD_HOLD      = 4'd3,
      ST_WR           = 4'd4,
      ST_WR_HOLD      = 4'd5,
      ST_FP_DEP       = 4'd6,
      ST_FP_EXAM      = 4'd7,
      ST_FP_EXAM_DATA = 4'd8
   } q2_state_e;

endpackage

// File: rtl/q2_sync_debounce.sv
// rtl/q2_sync_debounce.sv - two-flop synchronizer, stability filter and rising-edge pulse for one switch
module q2_sync_debounce
   import q2_bus_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE = DEBOUNCE_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic [1:0]  sync;
   logic        level;
   logic [15:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= 2'b00;
         level <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         sync <= {sync[0], din};
         rise <= 1'b0;
         // the counter only runs while the synced input disagrees with the accepted level
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt >= DEBOUNCE - 16'd1) begin
            cnt   <= '0;
            level <= sync[1];
            rise  <= sync[1];
         end else begin
            cnt <= cnt + 16'd1;
         end
      end
   end

endmodule

// File: rtl/q2_bus_responder.sv
// rtl/q2_bus_responder.sv - Q2 CPU bus memory/IO responder with front-panel deposit/examine
// Optional panel address pointer with auto-increment: define Q2_FP_AUTOINC_EN.
module q2_bus_responder
   import q2_bus_pkg::*;
#(
   parameter int                ADDR_W   = 12,
   parameter int                DATA_W   = 8,
   parameter logic [ADDR_W-1:0] IO_ADDR  = ADDR_W'(IO_ADDR_DEF),
   parameter logic [15:0]       DEBOUNCE = DEBOUNCE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_rd,
   input  logic              cpu_nwr,
   input  logic              cpu_io,
   input  logic [DATA_W-1:0] dbus_in,
   output logic [DATA_W-1:0] dbus_out,
   output logic              dbus_oe,
   output logic              cpu_ws,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] io_in,
   output logic [DATA_W-1:0] io_out,
   input  logic              fp_run,
   input  logic [ADDR_W-1:0] fp_addr_sw,
   input  logic [DATA_W-1:0] fp_data_sw,
   input  logic              fp_dep_sw,
   input  logic              fp_exam_sw,
   input  logic              fp_load_sw,
   output logic [ADDR_W-1:0] fp_addr_lamp,
   output logic [DATA_W-1:0] fp_data_lamp
);

   q2_state_e         state, state_nx;

   logic [1:0]        rd_sync, nwr_sync, io_sync, run_sync;
   logic [ADDR_W-1:0] fa_meta, fa_s;
   logic [DATA_W-1:0] fd_meta, fd_s;
   logic              rd_s, nwr_s, io_s, run_s;

   logic              dep_rise, exam_rise;
   logic              dep_pend, exam_pend, panel_take;
   logic [ADDR_W-1:0] panel_addr;

   logic [ADDR_W-1:0] addr_q;
   logic              io_hit_q;
   logic              cpu_hit;
   logic [DATA_W-1:0] dbus_q;
   logic [DATA_W-1:0] rd_src;

   // cpu_nwr is active low, so its synchronizer idles high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_sync  <= 2'b00;
         nwr_sync <= 2'b11;
         io_sync  <= 2'b00;
         run_sync <= 2'b00;
         fa_meta  <= '0;
         fa_s     <= '0;
         fd_meta  <= '0;
         fd_s     <= '0;
      end else begin
         rd_sync  <= {rd_sync[0], cpu_rd};
         nwr_sync <= {nwr_sync[0], cpu_nwr};
         io_sync  <= {io_sync[0], cpu_io};
         run_sync <= {run_sync[0], fp_run};
         fa_meta  <= fp_addr_sw;
         fa_s     <= fa_meta;
         fd_meta  <= fp_data_sw;
         fd_s     <= fd_meta;
      end
   end

   assign rd_s  = rd_sync[1];
   assign nwr_s = nwr_sync[1];
   assign io_s  = io_sync[1];
   assign run_s = run_sync[1];

   q2_sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_dep (
      .clk  (clk),
      .rst  (rst),
      .din  (fp_dep_sw),
      .rise (dep_rise)
   );

   q2_sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_exam (
      .clk  (clk),
      .rst  (rst),
      .din  (fp_exam_sw),
      .rise (exam_rise)
   );

   assign panel_take = (state == ST_IDLE) && !run_s && (dep_pend || exam_pend);

   // pending requests bridge a panel edge that lands while a CPU cycle is still finishing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dep_pend  <= 1'b0;
         exam_pend <= 1'b0;
      end else if (run_s || panel_take) begin
         dep_pend  <= 1'b0;
         exam_pend <= 1'b0;
      end else begin
         if (dep_rise)  dep_pend  <= 1'b1;
         if (exam_rise) exam_pend <= 1'b1;
      end
   end

`ifdef Q2_FP_AUTOINC_EN
   logic              load_rise;
   logic [ADDR_W-1:0] fp_ptr;

   q2_sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_load (
      .clk  (clk),
      .rst  (rst),
      .din  (fp_load_sw),
      .rise (load_rise)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fp_ptr <= '0;
      end else if (!run_s && load_rise) begin
         fp_ptr <= fa_s;
      end else if (panel_take) begin
         fp_ptr <= fp_ptr + ADDR_W'(1);
      end
   end

   assign panel_addr = fp_ptr;
`else
   logic unused_load;
   assign unused_load = fp_load_sw;
   assign panel_addr  = fa_s;
`endif

   assign cpu_hit  = io_s && (cpu_addr == IO_ADDR);
   assign rd_src   = io_hit_q ? io_in : mem_rdata;
   assign dbus_out = (state == ST_RD_DATA) ? rd_src : dbus_q;

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (run_s) begin
               if (!nwr_s)    state_nx = ST_WR;
               else if (rd_s) state_nx = ST_RD_ADDR;
            end else begin
               if (dep_pend)       state_nx = ST_FP_DEP;
               else if (exam_pend) state_nx = ST_FP_EXAM;
            end
         end
         ST_RD_ADDR:      state_nx = ST_RD_DATA;
         ST_RD_DATA:      state_nx = ST_RD_HOLD;
         ST_RD_HOLD:      if (!rd_s) state_nx = ST_IDLE;
         ST_WR:           state_nx = ST_WR_HOLD;
         ST_WR_HOLD:      if (nwr_s) state_nx = ST_IDLE;
         ST_FP_DEP:       state_nx = ST_IDLE;
         ST_FP_EXAM:      state_nx = ST_FP_EXAM_DATA;
         ST_FP_EXAM_DATA: state_nx = ST_IDLE;
         default:         state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         addr_q       <= '0;
         io_hit_q     <= 1'b0;
         dbus_q       <= '0;
         dbus_oe      <= 1'b0;
         cpu_ws       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_we       <= 1'b0;
         io_out       <= '0;
         fp_addr_lamp <= '0;
         fp_data_lamp <= '0;
      end else begin
         state   <= state_nx;
         mem_we  <= 1'b0;
         cpu_ws  <= (state_nx == ST_RD_DATA) || (state_nx == ST_RD_HOLD) ||
                    (state_nx == ST_WR_HOLD);
         dbus_oe <= (state_nx == ST_RD_DATA) || (state_nx == ST_RD_HOLD);
         case (state)
            ST_IDLE: begin
               if (state_nx == ST_WR || state_nx == ST_RD_ADDR) begin
                  addr_q   <= cpu_addr;
                  io_hit_q <= cpu_hit;
                  if (!cpu_hit) mem_addr <= cpu_addr;
               end else if (state_nx == ST_FP_DEP || state_nx == ST_FP_EXAM) begin
                  addr_q   <= panel_addr;
                  io_hit_q <= 1'b0;
                  mem_addr <= panel_addr;
                  if (state_nx == ST_FP_DEP) begin
                     mem_wdata <= fd_s;
                     mem_we    <= 1'b1;
                  end
               end
            end
            ST_RD_DATA: begin
               dbus_q       <= rd_src;
               fp_addr_lamp <= addr_q;
               fp_data_lamp <= rd_src;
            end
            ST_RD_HOLD: begin
               if (state_nx == ST_IDLE) dbus_q <= '0;
            end
            ST_WR: begin
               // an IO hit goes to the output latch and never touches RAM
               if (io_hit_q) begin
                  io_out <= dbus_in;
               end else begin
                  mem_wdata <= dbus_in;
                  mem_we    <= 1'b1;
               end
               fp_addr_lamp <= addr_q;
               fp_data_lamp <= dbus_in;
            end
            ST_FP_DEP: begin
               fp_addr_lamp <= addr_q;
               fp_data_lamp <= mem_wdata;
            end
            ST_FP_EXAM_DATA: begin
               fp_addr_lamp <= addr_q;
               fp_data_lamp <= mem_rdata;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_q2_bus_responder.sv
// tb/tb_q2_bus_responder.sv - self-checking bench for q2_bus_responder against a memory-map reference model
module tb_q2_bus_responder;

   localparam int          ADDR_W = 12;
   localparam int          DATA_W = 8;
   localparam logic [11:0] IO_A   = 12'hFFF;
   localparam int          DEB    = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] cpu_addr;
   logic        cpu_rd, cpu_nwr, cpu_io;
   logic [7:0]  dbus_in, dbus_out;
   logic        dbus_oe, cpu_ws;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_we;
   logic [7:0]  io_in, io_out;
   logic        fp_run;
   logic [11:0] fp_addr_sw;
   logic [7:0]  fp_data_sw;
   logic        fp_dep_sw, fp_exam_sw, fp_load_sw;
   logic [11:0] fp_addr_lamp;
   logic [7:0]  fp_data_lamp;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  ram     [0:4095];
   logic [7:0]  ref_mem [0:4095];
   logic [7:0]  io_out_m = 8'h00;
   logic [11:0] ptr_m    = 12'h000;

   int          we_count  = 0;
   int          we_double = 0;
   logic        we_prev   = 1'b0;
   logic [11:0] last_we_addr = 12'h000;
   logic [7:0]  last_we_data = 8'h00;

   always #5 clk = ~clk;

   q2_bus_responder #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .IO_ADDR  (IO_A),
      .DEBOUNCE (16'(DEB))
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_addr     (cpu_addr),
      .cpu_rd       (cpu_rd),
      .cpu_nwr      (cpu_nwr),
      .cpu_io       (cpu_io),
      .dbus_in      (dbus_in),
      .dbus_out     (dbus_out),
      .dbus_oe      (dbus_oe),
      .cpu_ws       (cpu_ws),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_rdata    (mem_rdata),
      .io_in        (io_in),
      .io_out       (io_out),
      .fp_run       (fp_run),
      .fp_addr_sw   (fp_addr_sw),
      .fp_data_sw   (fp_data_sw),
      .fp_dep_sw    (fp_dep_sw),
      .fp_exam_sw   (fp_exam_sw),
      .fp_load_sw   (fp_load_sw),
      .fp_addr_lamp (fp_addr_lamp),
      .fp_data_lamp (fp_data_lamp)
   );

   // synchronous block RAM with one cycle of read latency
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   always @(negedge clk) begin
      if (mem_we) begin
         we_count++;
         last_we_addr = mem_addr;
         last_we_data = mem_wdata;
         if (we_prev) we_double++;
      end
      we_prev = mem_we;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_write(input logic [11:0] a, input logic [7:0] d, input logic io);
      int   b;
      int   lat;
      logic hit;
      hit = io && (a == IO_A);
      b   = we_count;
      lat = 0;
      @(negedge clk);
      cpu_addr = a; dbus_in = d; cpu_io = io; cpu_nwr = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (cpu_ws) begin lat = i; break; end
      end
      check("wr_latency", 32'(lat), 32'd4);
      cpu_nwr = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (!cpu_ws) begin lat = i; break; end
      end
      check("wr_ws_release", 32'(lat != 0), 32'd1);
      cpu_io = 1'b0;
      if (hit) io_out_m = d; else ref_mem[a] = d;
      check("wr_pulses", 32'(we_count - b), hit ? 32'd0 : 32'd1);
      if (!hit) begin
         check("wr_mem_addr", 32'(last_we_addr), 32'(a));
         check("wr_mem_data", 32'(last_we_data), 32'(d));
      end
      check("wr_io_out", 32'(io_out), 32'(io_out_m));
      check("wr_lamp_addr", 32'(fp_addr_lamp), 32'(a));
      check("wr_lamp_data", 32'(fp_data_lamp), 32'(d));
   endtask

   task automatic cpu_read(input logic [11:0] a, input logic io);
      int         b;
      int         lat;
      logic [7:0] exp;
      exp = (io && (a == IO_A)) ? io_in : ref_mem[a];
      b   = we_count;
      lat = 0;
      @(negedge clk);
      cpu_addr = a; cpu_io = io; cpu_rd = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (cpu_ws) begin lat = i; break; end
      end
      check("rd_latency", 32'(lat), 32'd4);
      check("rd_oe", 32'(dbus_oe), 32'd1);
      check("rd_data", 32'(dbus_out), 32'(exp));
      repeat (3) @(negedge clk);
      check("rd_ws_hold", 32'(cpu_ws), 32'd1);
      check("rd_data_hold", 32'(dbus_out), 32'(exp));
      cpu_rd = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (!cpu_ws) begin lat = i; break; end
      end
      check("rd_ws_release", 32'(lat != 0), 32'd1);
      check("rd_oe_release", 32'(dbus_oe), 32'd0);
      cpu_io = 1'b0;
      check("rd_no_write", 32'(we_count - b), 32'd0);
      check("rd_lamp_addr", 32'(fp_addr_lamp), 32'(a));
      check("rd_lamp_data", 32'(fp_data_lamp), 32'(exp));
   endtask

   task automatic press(input logic dep, input logic exam, input logic load);
      @(negedge clk);
      fp_dep_sw = dep; fp_exam_sw = exam; fp_load_sw = load;
      repeat (DEB + 8) @(negedge clk);
      fp_dep_sw = 1'b0; fp_exam_sw = 1'b0; fp_load_sw = 1'b0;
      repeat (DEB + 8) @(negedge clk);
   endtask

   task automatic next_panel_addr(output logic [11:0] pa);
`ifdef Q2_FP_AUTOINC_EN
      pa    = ptr_m;
      ptr_m = ptr_m + 12'd1;
`else
      pa = fp_addr_sw;
`endif
   endtask

   task automatic panel_load(input logic [11:0] a);
      fp_addr_sw = a;
      press(1'b0, 1'b0, 1'b1);
`ifdef Q2_FP_AUTOINC_EN
      ptr_m = a;
`endif
   endtask

   task automatic panel_deposit(input logic [11:0] a, input logic [7:0] d, input logic with_exam);
      int          b;
      logic [11:0] pa;
      fp_addr_sw = a; fp_data_sw = d;
      next_panel_addr(pa);
      b = we_count;
      press(1'b1, with_exam, 1'b0);
      ref_mem[pa] = d;
      check("dep_pulses", 32'(we_count - b), 32'd1);
      check("dep_mem_addr", 32'(last_we_addr), 32'(pa));
      check("dep_mem_data", 32'(last_we_data), 32'(d));
      check("dep_lamp_addr", 32'(fp_addr_lamp), 32'(pa));
      check("dep_lamp_data", 32'(fp_data_lamp), 32'(d));
   endtask

   task automatic panel_examine(input logic [11:0] a);
      int          b;
      logic [11:0] pa;
      fp_addr_sw = a; fp_data_sw = 8'h00;
      next_panel_addr(pa);
      b = we_count;
      press(1'b0, 1'b1, 1'b0);
      check("exam_no_write", 32'(we_count - b), 32'd0);
      check("exam_lamp_addr", 32'(fp_addr_lamp), 32'(pa));
      check("exam_lamp_data", 32'(fp_data_lamp), 32'(ref_mem[pa]));
   endtask

   initial begin
      int          b;
      logic [11:0] a;
      logic [7:0]  d;
      logic        io;

      for (int i = 0; i < 4096; i++) begin
         ram[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      rst = 1'b1;
      cpu_addr = 12'h000; cpu_rd = 1'b0; cpu_nwr = 1'b1; cpu_io = 1'b0;
      dbus_in = 8'h00; io_in = 8'h00;
      fp_run = 1'b0; fp_addr_sw = 12'h000; fp_data_sw = 8'h00;
      fp_dep_sw = 1'b0; fp_exam_sw = 1'b0; fp_load_sw = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_dbus_out", 32'(dbus_out), 32'd0);
      check("rst_dbus_oe", 32'(dbus_oe), 32'd0);
      check("rst_cpu_ws", 32'(cpu_ws), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_io_out", 32'(io_out), 32'd0);
      check("rst_addr_lamp", 32'(fp_addr_lamp), 32'd0);
      check("rst_data_lamp", 32'(fp_data_lamp), 32'd0);

      rst = 1'b0;
      fp_run = 1'b1;
      repeat (4) @(negedge clk);

      cpu_write(12'h123, 8'h5A, 1'b0);
      cpu_read(12'h123, 1'b0);

      cpu_write(IO_A, 8'h3C, 1'b1);
      io_in = 8'($urandom);
      cpu_read(IO_A, 1'b1);
      cpu_write(IO_A, 8'h77, 1'b0);
      cpu_read(IO_A, 1'b0);
      cpu_write(12'h0FE, 8'hC3, 1'b1);
      cpu_read(12'h0FE, 1'b0);
      check("io_out_kept", 32'(io_out), 32'h3C);

      for (int k = 0; k < 24; k++) begin
         a  = ($urandom_range(0, 5) == 0) ? IO_A : 12'h100 + 12'($urandom_range(0, 15));
         io = 1'($urandom_range(0, 1));
         d  = 8'($urandom);
         io_in = 8'($urandom);
         if ($urandom_range(0, 1) == 0) cpu_write(a, d, io);
         else                           cpu_read(a, io);
      end

      // reset while read data is on the bus
      @(negedge clk);
      cpu_addr = 12'h123; cpu_io = 1'b0; cpu_rd = 1'b1;
      b = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (cpu_ws) begin b = i; break; end
      end
      check("rstrd_reached", 32'(b), 32'd4);
      rst = 1'b1;
      #1;
      check("rstrd_ws", 32'(cpu_ws), 32'd0);
      check("rstrd_oe", 32'(dbus_oe), 32'd0);
      cpu_rd = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      io_out_m = 8'h00;
      check("rstrd_io_out", 32'(io_out), 32'd0);
      check("rstrd_lamp", 32'(fp_data_lamp), 32'd0);
      repeat (4) @(negedge clk);
      cpu_read(12'h123, 1'b0);

      // reset before the write strobe reaches RAM
      @(negedge clk);
      b = we_count;
      cpu_addr = 12'h155; dbus_in = 8'hEE; cpu_io = 1'b0; cpu_nwr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      cpu_nwr = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("rstwr_discard", 32'(we_count - b), 32'd0);
      cpu_read(12'h155, 1'b0);

      // panel edges while running are dropped
      fp_addr_sw = 12'h055; fp_data_sw = 8'h99;
      b = we_count;
      press(1'b1, 1'b0, 1'b0);
      fp_run = 1'b0;
      repeat (DEB + 8) @(negedge clk);
      check("run_panel_ignored", 32'(we_count - b), 32'd0);

      // CPU strobes while halted are ignored
      b = we_count;
      cpu_addr = 12'h130; dbus_in = 8'h42; cpu_nwr = 1'b0;
      repeat (20) @(negedge clk);
      check("halt_cpu_ws", 32'(cpu_ws), 32'd0);
      check("halt_cpu_we", 32'(we_count - b), 32'd0);
      cpu_nwr = 1'b1;
      repeat (4) @(negedge clk);

      panel_load(12'h040);
      panel_deposit(12'h040, 8'hA5, 1'b0);
      panel_load(12'h040);
      panel_examine(12'h040);

      // bounce shorter than the debounce window
      b = we_count;
      for (int k = 0; k < 4; k++) begin
         fp_dep_sw = 1'b1;
         repeat (DEB / 2) @(negedge clk);
         fp_dep_sw = 1'b0;
         repeat (DEB / 2) @(negedge clk);
      end
      repeat (DEB + 8) @(negedge clk);
      check("bounce_no_action", 32'(we_count - b), 32'd0);

      panel_load(12'h222);
      panel_deposit(12'h222, 8'h4D, 1'b1);

      panel_load(12'hFFF);
      panel_deposit(12'hFFF, 8'h11, 1'b0);
      panel_deposit(12'hFFF, 8'h22, 1'b0);

      panel_load(12'h222);
      panel_examine(12'h222);

      check("single_cycle_we", 32'(we_double), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
